// File: rtl/uart_pkg.sv
// Shared UART definitions: byte/word geometry, packer FSM states, keep-mask helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FLUSH
    } rx_state_t;

    // Keep mask covering the low n bytes of a word (n = 1..3 for partials).
    function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [1:0] n);
        return (4'b0001 << n) - 4'b0001;
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Idle counter: clear/enable counter with a terminal-count strobe at TIMEOUT_CYCLES-1.
// Latency: tc is combinational from the count register; count updates each clock.
// Backpressure: none; the counter holds at terminal count until cleared.
//
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over en),
//        en (count enable), tc (count == TIMEOUT_CYCLES-1).
module uart_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] idle_cnt;

    assign tc = (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (clr) begin
            idle_cnt <= '0;
        end else if (en && !tc) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes into 32-bit little-endian words; partials flush on idle timeout or request.
// Latency: word valid one cycle after its 4th byte or after the flush decision (slot free).
// Backpressure: in_rdy drops only with 3 bytes held and the output stalled, or while a flush waits for the slot.
//
// Ports: clk, rst_n (async active-low); in_vld/in_data/in_rdy byte side;
//        flush (pulse, emits pending partial); out_vld/out_data/out_keep/out_rdy word side.
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    input  logic [BYTE_W-1:0]         in_data,
    output logic                      in_rdy,
    input  logic                      flush,
    output logic                      out_vld,
    output logic [WORD_W-1:0]         out_data,
    output logic [BYTES_PER_WORD-1:0] out_keep,
    input  logic                      out_rdy
);

    rx_state_t                state, state_nxt;
    logic [23:0]              acc, acc_nxt;
    logic [1:0]               cnt, cnt_nxt;
    logic                     slot_free;
    logic                     accept;
    logic                     tmr_clr, tmr_en, tmr_tc;
    logic                     load;
    logic [WORD_W-1:0]        load_data;
    logic [BYTES_PER_WORD-1:0] load_keep;

    assign slot_free = !out_vld || out_rdy;

    uart_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .tc   (tmr_tc)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        in_rdy    = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        load_data = '0;
        load_keep = '0;

        case (state)
            EMPTY: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    accept    = 1'b1;
                    acc_nxt   = {16'h0000, in_data};
                    cnt_nxt   = 2'd1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                in_rdy = !((cnt == 2'd3) && !slot_free);
                accept = in_vld && in_rdy;
                // An accepted byte always beats a coincident timeout or flush.
                if (accept) begin
                    if (cnt == 2'd3) begin
                        load      = 1'b1;
                        load_data = {in_data, acc};
                        load_keep = 4'hF;
                        acc_nxt   = '0;
                        cnt_nxt   = 2'd0;
                        state_nxt = EMPTY;
                    end else begin
                        acc_nxt[{cnt, 3'b000} +: 8] = in_data;
                        cnt_nxt = cnt + 2'd1;
                    end
                end else if (flush || tmr_tc) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_data = {8'h00, acc};
                        load_keep = keep_mask(cnt);
                        acc_nxt   = '0;
                        cnt_nxt   = 2'd0;
                        state_nxt = EMPTY;
                    end else begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = {8'h00, acc};
                    load_keep = keep_mask(cnt);
                    acc_nxt   = '0;
                    cnt_nxt   = 2'd0;
                    state_nxt = EMPTY;
                end
            end
            default: begin
                acc_nxt   = '0;
                cnt_nxt   = 2'd0;
                state_nxt = EMPTY;
            end
        endcase

        // Idle time only accrues while a partial word sits in FILL.
        tmr_clr = (state != FILL) || accept;
        tmr_en  = (state == FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            acc   <= '0;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One-entry output register; a load in the same cycle as out_rdy gives zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_keep <= '0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_data <= load_data;
            out_keep <= load_keep;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Bench for uart_rx_packer: directed scenarios plus random traffic against a byte-queue reference model.
// Latency: n/a.
// Backpressure: out_rdy driven randomly and held low in stall scenarios.
module tb_uart_rx_packer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic [7:0]  in_data;
    logic        in_rdy;
    logic        flush;
    logic        out_vld;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_rdy;

    always #5 clk = ~clk;

    uart_rx_packer #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_data (in_data),
        .in_rdy  (in_rdy),
        .flush   (flush),
        .out_vld (out_vld),
        .out_data(out_data),
        .out_keep(out_keep),
        .out_rdy (out_rdy)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] cur[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_acc = 0;
    word_t      w;
    logic       exp_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: a word is the accepted bytes in arrival order, little-endian,
    // cut at 4 bytes or when a flush/timeout hits a non-empty partial.
    function automatic word_t make_partial();
        word_t r;
        r.d = '0;
        for (int i = 0; i < cur.size(); i++) r.d[8*i +: 8] = cur[i];
        r.k = 4'((1 << cur.size()) - 1);
        return r;
    endfunction

    // Monitor / scoreboard, sampling at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cur.delete();
        end else begin
            // Pending words: 1 = output register full, 2 = a flushed partial is also waiting.
            chk("out_vld", {31'd0, out_vld}, {31'd0, exp_q.size() > 0});
            exp_rdy = !((exp_q.size() >= 2) ||
                        (cur.size() == 3 && exp_q.size() == 1 && !out_rdy));
            chk("in_rdy", {31'd0, in_rdy}, {31'd0, exp_rdy});

            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word at cycle %0d: got %h keep %h, expected none",
                             cyc, out_data, out_keep);
                end else begin
                    w = exp_q.pop_front();
                    chk("out_data", out_data, w.d);
                    chk("out_keep", {28'd0, out_keep}, {28'd0, w.k});
                end
            end

            if (in_vld && in_rdy) begin
                cur.push_back(in_data);
                last_acc = cyc;
                if (cur.size() == 4) begin
                    exp_q.push_back(make_partial());
                    cur.delete();
                end
            end else if (cur.size() > 0 && (flush || (cyc - last_acc == TO))) begin
                exp_q.push_back(make_partial());
                cur.delete();
            end
        end
        cyc++;
    end

    // One clock of stimulus, driven just after the rising edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit f, input bit r, output bit acc);
        in_vld  = v;
        in_data = d;
        flush   = f;
        out_rdy = r;
        @(negedge clk);
        acc = v && in_rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit r);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 64 && !a; i++) cycle(1'b1, d, 1'b0, r, a);
        if (!a) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: byte %h not accepted within 64 cycles, expected acceptance", d);
        end
        in_vld = 1'b0;
    endtask

    task automatic idle(input int n, input bit r);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, r, a);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_keep", {28'd0, out_keep}, 32'd0);
        chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    endtask

    initial begin
        bit a;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_data = 8'h00;
        flush   = 1'b0;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Single word, free-flowing output.
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
        idle(3, 1'b1);

        // Twelve bytes with the output stalled through the 8th byte.
        for (int i = 0; i < 7; i++) send(8'(8'h50 + i), 1'b0);
        repeat (3) cycle(1'b1, 8'h57, 1'b0, 1'b0, a);
        send(8'h57, 1'b1);
        for (int i = 8; i < 12; i++) send(8'(8'h50 + i), 1'b1);
        idle(4, 1'b1);

        // Idle timeout on a two-byte partial.
        send(8'hAA, 1'b1); send(8'hBB, 1'b1);
        idle(TO + 5, 1'b1);

        // Flush with the output stalled: waits in FLUSH, then drains.
        send(8'hC0, 1'b0); send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
        idle(2, 1'b0);
        repeat (2) cycle(1'b1, 8'h99, 1'b0, 1'b0, a);
        in_vld = 1'b0;
        idle(5, 1'b1);

        // Flush with nothing held produces nothing.
        cycle(1'b0, 8'h00, 1'b1, 1'b1, a);
        idle(3, 1'b1);

        // Byte coincident with the timeout, then coincident with flush.
        send(8'hD1, 1'b1);
        idle(TO - 1, 1'b1);
        cycle(1'b1, 8'hD2, 1'b0, 1'b1, a);
        idle(TO - 1, 1'b1);
        cycle(1'b1, 8'hD3, 1'b1, 1'b1, a);
        idle(TO + 5, 1'b1);

        // Reset mid-word with a stalled output word.
        send(8'hE0, 1'b0); send(8'hE1, 1'b0); send(8'hE2, 1'b0); send(8'hE3, 1'b0);
        send(8'hE4, 1'b0); send(8'hE5, 1'b0);
        in_vld = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'hF0, 1'b1); send(8'hF1, 1'b1); send(8'hF2, 1'b1); send(8'hF3, 1'b1);
        idle(3, 1'b1);

        // Dense random traffic.
        repeat (3000)
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0, a);
        // Sparse traffic so idle timeouts fire.
        repeat (1500)
            cycle($urandom_range(0, 11) == 0, 8'($urandom), $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) != 0, a);

        in_vld = 1'b0;
        flush  = 1'b0;
        idle(TO + 40, 1'b1);
        chk("drain_empty", 32'(exp_q.size() + cur.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
